fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, the number of write requesters (2..8).
REQ-002 The block SHALL have parameter DW, default 8, the FIFO data width.
REQ-003 The block SHALL have port wclk  input  1  write-domain clock; all state changes on its rising edge.
REQ-004 The block SHALL have port wrst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid  input  NREQ  per-requester beat valid.
REQ-006 The block SHALL have port req_data  input  NREQ*DW  per-requester beat data; requester i occupies bits [i*DW +: DW].
REQ-007 The block SHALL have port req_last  input  NREQ  marks the final beat of a requester's packet.
REQ-008 The block SHALL have port req_ready  output  NREQ  per-requester beat accept.
REQ-009 The block SHALL have port wfull  input  1  FIFO full flag from the write-pointer logic.
REQ-010 The block SHALL have port winc  output  1  FIFO write strobe, one entry per cycle high.
REQ-011 The block SHALL have port wdata  output  DW  FIFO write data.
REQ-012 The block SHALL have port grant_id  output  $clog2(NREQ)  index of the current owner.
REQ-013 The block SHALL have port busy  output  1  high while a packet is locked.
REQ-014 The block SHALL have port wr_count  output  16  total beats written, saturating at 16'hFFFF.

Function
REQ-015 The state machine SHALL have two states: IDLE and LOCK.
REQ-016 In IDLE with any req_valid high, the block SHALL select the first valid requester strictly after rr_ptr in ascending, wrapping order, register it into grant_id and move to LOCK next cycle.
REQ-017 In IDLE, req_ready SHALL be all-zero and winc SHALL be 0 (one-cycle arbitration bubble).
REQ-018 In LOCK, req_ready[grant_id] SHALL equal !wfull; all other req_ready bits SHALL be 0.
REQ-019 winc SHALL equal req_valid[grant_id] & req_ready[grant_id] combinationally, and wdata SHALL be req_data of grant_id combinationally (zero-cycle datapath).
REQ-020 A beat accepted with req_last high SHALL return the FSM to IDLE and load rr_ptr with grant_id on the same edge.
REQ-021 While locked, the grant SHALL NOT change regardless of other requests, req_valid gaps or wfull duration.
REQ-022 wfull high SHALL hold winc low with no beat lost or duplicated; transfer resumes the cycle wfull falls.
REQ-023 busy SHALL be high exactly when the state is LOCK.
REQ-024 wr_count SHALL increment by 1 on every cycle winc is high and hold at 16'hFFFF.
REQ-025 A requester deasserting req_valid mid-packet SHALL keep its lock; no timeout applies.

Reset
REQ-026 On wrst high, the block SHALL immediately enter IDLE, with grant_id=0, rr_ptr=NREQ-1 (so requester 0 wins first), wr_count=0, busy=0, req_ready=0 and winc=0.
REQ-027 Reset asserted mid-packet SHALL abandon the packet; after release the first grant SHALL follow REQ-016 from the reset rr_ptr.

Structure
REQ-028 A shared package fifo_pkg SHALL hold the state enum (IDLE, LOCK) and default NREQ/DW constants.
REQ-029 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs: request vector, rr_ptr; outputs: found, index).

Verification
REQ-030 Reset release with req_valid=4'b0001, 3-beat packet (last on beat 3) -> grant_id=0, winc high cycles 2..4 after request, busy falls after beat 3, wr_count=3.
REQ-031 All four requesters continuously valid with 1-beat packets -> grant order 0,1,2,3,0; winc high every other cycle.
REQ-032 Requester 2 locked, wfull high for 5 cycles mid-packet -> winc=0 and req_ready=0 throughout; the same beat is written on the first cycle after wfull falls.
REQ-033 Requester 1 locked, requester 3 asserts valid mid-packet -> requester 3 receives no req_ready until requester 1's last beat; it is granted next.
REQ-034 wrst pulsed during a locked packet -> outputs reach reset values without a clock edge; with requests 4'b1010 next grant is requester 1.
REQ-035 Preload wr_count near 16'hFFFF via 65535+ writes -> wr_count holds 16'hFFFF with winc still operating.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side arbiter: FSM state encoding and
// default sizing constants.
package fifo_pkg;

  // Arbiter FSM states: IDLE arbitrates, LOCK streams the owner's packet.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int DEF_NREQ = 4;
  localparam int DEF_DW   = 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: finds the first asserted request strictly
// after i_ptr, searching in ascending order and wrapping past NREQ-1 to 0.
module rr_picker
  import fifo_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic            o_found,
  output logic [IW-1:0]   o_index
);

  logic [IW-1:0] w_cand;

  // Walk candidates from farthest to nearest so the nearest hit is kept last.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    w_cand  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      w_cand = IW'((int'(i_ptr) + k) % NREQ);
      if (i_req[w_cand]) begin
        o_found = 1'b1;
        o_index = w_cand;
      end else begin
        o_found = o_found;
        o_index = o_index;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter feeding the write port of a FIFO.
// A winner is chosen in IDLE (one bubble cycle), then owns the write port in
// LOCK until its beat carrying req_last is accepted. Datapath is zero-cycle.
module fifo_wr_arbiter
  import fifo_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int DW   = DEF_DW
) (
  input  logic                     wclk,
  input  logic                     wrst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DW-1:0]       req_data,
  input  logic [NREQ-1:0]          req_last,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wfull,
  output logic                     winc,
  output logic [DW-1:0]            wdata,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic [15:0]              wr_count
);

  localparam int IW = $clog2(NREQ);

  state_t        r_state;
  logic [IW-1:0] r_grant;
  logic [IW-1:0] r_rr_ptr;
  logic [15:0]   r_count;

  logic          w_found;
  logic [IW-1:0] w_pick;
  logic          w_lock;
  logic          w_accept_en;
  logic          w_sel_last;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .i_req   (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_index (w_pick)
  );

  assign w_lock      = (r_state == LOCK);
  assign w_accept_en = w_lock & ~wfull;
  assign w_sel_last  = req_last[r_grant];

  // Only the current owner may see ready, and only while the FIFO has room.
  always_comb begin
    req_ready          = '0;
    req_ready[r_grant] = w_accept_en;
  end

  assign winc     = req_valid[r_grant] & w_accept_en;
  assign wdata    = req_data[r_grant*DW +: DW];
  assign grant_id = r_grant;
  assign busy     = w_lock;
  assign wr_count = r_count;

  // Arbitration FSM: grab a winner in IDLE, release on the accepted last beat.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_state  <= IDLE;
      r_grant  <= '0;
      r_rr_ptr <= IW'(NREQ - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_state <= LOCK;
          end
        end
        LOCK: begin
          if (winc && w_sel_last) begin
            r_state  <= IDLE;
            r_rr_ptr <= r_grant;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Saturating count of beats written into the FIFO.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_count <= 16'h0000;
    end else if (winc && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'h0001;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized
// traffic, all compared against a packet-level reference model.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IW   = $clog2(NREQ);

  logic              wclk;
  logic              wrst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              wfull;
  logic              winc;
  logic [DW-1:0]     wdata;
  logic [IW-1:0]     grant_id;
  logic              busy;
  logic [15:0]       wr_count;

  int errors = 0;
  int checks = 0;

  // Requester traffic: beats remaining in the current packet, beat serial, gaps.
  int rem [NREQ];
  int bc  [NREQ];
  bit gap [NREQ];

  // Reference model: who owns the port, who won last, how many beats written.
  bit m_locked;
  int m_owner;
  int m_ptr;
  int m_count;

  logic [NREQ-1:0] exp_ready;
  logic            exp_winc;
  logic [DW-1:0]   exp_wdata;
  int              exp_grant;
  logic            exp_busy;
  int              exp_count;

  fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW)) dut (
    .wclk      (wclk),
    .wrst      (wrst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wfull     (wfull),
    .winc      (winc),
    .wdata     (wdata),
    .grant_id  (grant_id),
    .busy      (busy),
    .wr_count  (wr_count)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int m_pick(logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_ptr    = NREQ - 1;
    m_count  = 0;
  endtask

  task automatic m_expect();
    exp_busy  = m_locked;
    exp_grant = m_owner;
    exp_count = m_count;
    exp_ready = '0;
    if (m_locked && !wfull) exp_ready[m_owner] = 1'b1;
    exp_winc  = m_locked && !wfull && req_valid[m_owner];
    exp_wdata = req_data[m_owner*DW +: DW];
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (rem[i] > 0) && !gap[i];
      req_last[i]  = (rem[i] == 1);
      req_data[i*DW +: DW] = DW'((i << 4) | (bc[i] & 15));
    end
  endtask

  task automatic settle();
    @(negedge wclk);
    m_expect();
  endtask

  task automatic advance();
    int p;
    m_expect();
    if (!m_locked) begin
      p = m_pick(req_valid);
      if (p >= 0) begin
        m_locked = 1'b1;
        m_owner  = p;
      end
    end else if (exp_winc) begin
      if (m_count < 65535) m_count++;
      if (req_last[m_owner]) begin
        m_locked = 1'b0;
        m_ptr    = m_owner;
      end
      rem[m_owner]--;
      bc[m_owner]++;
    end
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    wrst  = 1'b1;
    wfull = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0; bc[i] = 0; gap[i] = 1'b0;
    end
    drive();
    @(posedge wclk);
    #1;
    wrst = 1'b0;
    m_reset();
  endtask

  task automatic test_reset();
    wrst  = 1'b0;
    wfull = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0; bc[i] = 0; gap[i] = 1'b0;
    end
    drive();
    #1 wrst = 1'b1;
    #2;
    checks++;
    if (busy !== 1'b0 || winc !== 1'b0 || req_ready !== 4'b0000 ||
        grant_id !== 2'd0 || wr_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_values: busy=%b winc=%b ready=%b grant=%0d count=%0h, required 0", busy, winc, req_ready, grant_id, wr_count);
    end
    @(posedge wclk);
    #1 wrst = 1'b0;
    m_reset();
    settle();
    checks++;
    if (busy !== 1'b0 || winc !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b winc=%b, required 0 0", busy, winc);
    end
    advance();
  endtask

  task automatic test_single_packet();
    logic [5:0] hist;
    do_reset();
    rem[0] = 3;
    hist = '0;
    for (int c = 0; c < 6; c++) begin
      drive();
      settle();
      hist[c] = winc;
      checks++;
      if (winc !== exp_winc || busy !== exp_busy || grant_id !== IW'(exp_grant)) begin
        errors++;
        $display("FAIL single_cycle%0d: winc=%b busy=%b grant=%0d, required %b %b %0d", c, winc, busy, grant_id, exp_winc, exp_busy, exp_grant);
      end
      advance();
    end
    checks++;
    if (hist !== 6'b001110) begin
      errors++;
      $display("FAIL single_winc_pattern: got %b required 001110", hist);
    end
    checks++;
    if (wr_count !== 16'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_count: count=%0d busy=%b, required 3 0", wr_count, busy);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    logic [9:0] hist;
    int want[5] = '{0, 1, 2, 3, 0};
    do_reset();
    hist = '0;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < NREQ; i++) if (rem[i] == 0) rem[i] = 1;
      drive();
      settle();
      hist[c] = winc;
      if (winc) order.push_back(int'(grant_id));
      checks++;
      if (req_ready !== exp_ready || winc !== exp_winc) begin
        errors++;
        $display("FAIL rr_cycle%0d: ready=%b winc=%b, required %b %b", c, req_ready, winc, exp_ready, exp_winc);
      end
      advance();
    end
    checks++;
    if (hist !== 10'b1010101010) begin
      errors++;
      $display("FAIL rr_winc_pattern: got %b required 1010101010", hist);
    end
    checks++;
    if (order.size() != 5) begin
      errors++;
      $display("FAIL rr_order_len: got %0d required 5", order.size());
    end else begin
      for (int j = 0; j < 5; j++) begin
        if (order[j] != want[j]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got %0d required %0d", j, order[j], want[j]);
        end
      end
    end
  endtask

  task automatic test_wfull_stall();
    logic [DW-1:0] wr[$];
    int third_cycle;
    logic [DW-1:0] want[4] = '{8'h20, 8'h21, 8'h22, 8'h23};
    do_reset();
    rem[2] = 4;
    third_cycle = -1;
    for (int c = 0; c < 12; c++) begin
      wfull = (c >= 3 && c <= 7);
      drive();
      settle();
      checks++;
      if (winc !== exp_winc || req_ready !== exp_ready || wdata !== exp_wdata) begin
        errors++;
        $display("FAIL stall_cycle%0d: winc=%b ready=%b wdata=%h, required %b %b %h", c, winc, req_ready, wdata, exp_winc, exp_ready, exp_wdata);
      end
      if (wfull) begin
        checks++;
        if (winc !== 1'b0 || req_ready !== 4'b0000 || busy !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold%0d: winc=%b ready=%b busy=%b, required 0 0000 1", c, winc, req_ready, busy);
        end
      end
      if (winc) begin
        wr.push_back(wdata);
        if (wr.size() == 3) third_cycle = c;
      end
      advance();
    end
    wfull = 1'b0;
    checks++;
    if (third_cycle != 8) begin
      errors++;
      $display("FAIL stall_resume: third beat at cycle %0d required 8", third_cycle);
    end
    checks++;
    if (wr.size() != 4) begin
      errors++;
      $display("FAIL stall_beats: got %0d beats required 4", wr.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (wr[j] !== want[j]) begin
          errors++;
          $display("FAIL stall_data[%0d]: got %h required %h", j, wr[j], want[j]);
        end
      end
    end
  endtask

  task automatic test_no_preempt();
    int owners[$];
    int want[4] = '{1, 1, 1, 3};
    do_reset();
    rem[1] = 3;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) rem[3] = 1;
      drive();
      settle();
      checks++;
      if (req_ready !== exp_ready || grant_id !== IW'(exp_grant)) begin
        errors++;
        $display("FAIL preempt_cycle%0d: ready=%b grant=%0d, required %b %0d", c, req_ready, grant_id, exp_ready, exp_grant);
      end
      if (busy && grant_id == 2'd1) begin
        checks++;
        if (req_ready[3] !== 1'b0) begin
          errors++;
          $display("FAIL preempt_ready3: got %b required 0", req_ready[3]);
        end
      end
      if (winc) owners.push_back(int'(grant_id));
      advance();
    end
    checks++;
    if (owners.size() != 4) begin
      errors++;
      $display("FAIL preempt_len: got %0d required 4", owners.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        if (owners[j] != want[j]) begin
          errors++;
          $display("FAIL preempt_order[%0d]: got %0d required %0d", j, owners[j], want[j]);
        end
      end
    end
  endtask

  task automatic test_reset_midpacket();
    do_reset();
    rem[2] = 6;
    for (int c = 0; c < 3; c++) begin
      drive();
      advance();
    end
    #2 wrst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || winc !== 1'b0 || req_ready !== 4'b0000 ||
        grant_id !== 2'd0 || wr_count !== 16'h0000) begin
      errors++;
      $display("FAIL midreset_async: busy=%b winc=%b ready=%b grant=%0d count=%0h, required 0", busy, winc, req_ready, grant_id, wr_count);
    end
    @(posedge wclk);
    #1 wrst = 1'b0;
    m_reset();
    rem[2] = 0; rem[1] = 1; rem[3] = 1;
    drive();
    settle();
    advance();
    settle();
    checks++;
    if (grant_id !== 2'd1 || busy !== 1'b1 || grant_id !== IW'(exp_grant)) begin
      errors++;
      $display("FAIL midreset_grant: grant=%0d busy=%b, required 1 1", grant_id, busy);
    end
    advance();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rem[i] == 0 && $urandom_range(0, 2) == 0) rem[i] = int'($urandom_range(1, 5));
        gap[i] = ($urandom_range(0, 4) == 0);
      end
      wfull = ($urandom_range(0, 3) == 0);
      drive();
      settle();
      checks++;
      if (req_ready !== exp_ready || winc !== exp_winc || wdata !== exp_wdata ||
          grant_id !== IW'(exp_grant) || busy !== exp_busy || wr_count !== 16'(exp_count)) begin
        errors++;
        $display("FAIL rand_cycle%0d: ready=%b winc=%b wdata=%h grant=%0d busy=%b count=%0d, required %b %b %h %0d %b %0d",
                 c, req_ready, winc, wdata, grant_id, busy, wr_count,
                 exp_ready, exp_winc, exp_wdata, exp_grant, exp_busy, exp_count);
      end
      advance();
    end
    for (int i = 0; i < NREQ; i++) gap[i] = 1'b0;
    wfull = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    rem[0] = 70000;
    for (int c = 0; c < 65540; c++) begin
      drive();
      advance();
    end
    drive();
    settle();
    checks++;
    if (wr_count !== 16'hFFFF || winc !== 1'b1 || wr_count !== 16'(exp_count)) begin
      errors++;
      $display("FAIL sat_reach: count=%h winc=%b, required ffff 1", wr_count, winc);
    end
    advance();
    drive();
    settle();
    checks++;
    if (wr_count !== 16'hFFFF || winc !== 1'b1) begin
      errors++;
      $display("FAIL sat_hold: count=%h winc=%b, required ffff 1", wr_count, winc);
    end
    advance();
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_wfull_stall();
    test_no_preempt();
    test_reset_midpacket();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
